// File: rtl/multiexp_pnt_scl_replay_if.sv
// Valid/ready stream carrying one {point, scalar} pair per beat.
//   val/rdy  : handshake (transfer when both high at a clock edge)
//   sop/eop  : packet delimiters
//   ctl/err  : sideband control and error flag
//   mod      : byte count of a partial last word (0 = full word)
//   dat      : payload word, DAT_BYTS bytes wide
interface multiexp_pnt_scl_replay_if #(
    parameter int unsigned DAT_BYTS = 224,
    parameter int unsigned CTL_BITS = 8
);
    localparam int unsigned MOD_W = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [CTL_BITS-1:0]   ctl;
    logic [MOD_W-1:0]      mod;
    logic [DAT_BYTS*8-1:0] dat;

    modport master (output val, sop, eop, err, ctl, mod, dat, input rdy);
    modport slave  (input val, sop, eop, err, ctl, mod, dat, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_replay.sv
// Point/scalar replay feeder for the G2 multiexp core.
// Loads n pairs once from the host and then replays the whole set SCL_BITS
// times, one pass per scalar bit.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_num_in      : pair count, sampled with the first accepted load beat
//   i_pnt_scl_if  : host pair stream (slave), one pair per beat
//   o_pnt_scl_if  : replayed pair stream to the core (master)
//   o_busy        : job in progress (load + replay)
//   o_pass        : pass index of the most recently delivered beat
//   o_err         : sticky bad-count flag, cleared only by reset
module multiexp_pnt_scl_replay #(
    parameter int unsigned DAT_W    = 1792,
    parameter int unsigned SCL_BITS = 256,
    parameter int unsigned MAX_IN   = 1024,
    parameter int unsigned CTL_BITS = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [63:0]                 i_num_in,
    multiexp_pnt_scl_replay_if.slave    i_pnt_scl_if,
    multiexp_pnt_scl_replay_if.master   o_pnt_scl_if,
    output logic                        o_busy,
    output logic [$clog2(SCL_BITS)-1:0] o_pass,
    output logic                        o_err
);
    localparam int unsigned DAT_BYTS = (DAT_W + 7) / 8;
    localparam int unsigned BUS_W    = DAT_BYTS * 8;
    localparam int unsigned AW       = $clog2(MAX_IN);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned PW       = $clog2(SCL_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REPLAY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DAT_W-1:0]  ram [MAX_IN];
    logic [CW-1:0]     n_q, wr_addr_q, rd_addr_q, out_addr_q;
    logic [PW-1:0]     rd_pass_q, out_pass_q, pass_q;
    logic              issue_done_q;
    logic              rd_vld_q;
    logic [DAT_W-1:0]  rd_dat_q;
    logic [DAT_W-1:0]  skid_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              rdy_q, val_q, busy_q, err_q;

    logic              in_hs, num_bad, start, ram_we, pop, issue;
    logic              last_wr, last_out, rdy_d, busy_d;
    logic [CW-1:0]     n_last;
    logic [AW-1:0]     wr_idx;
    logic [2:0]        occ;

    // Input sideband is ignored: every beat is exactly one pair
    logic unused_in;
    assign unused_in = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.ctl,
                         i_pnt_scl_if.err, i_pnt_scl_if.mod};

    // Next state, handshake decode and read-issue control
    always_comb begin
        state_d  = state_q;
        in_hs    = i_pnt_scl_if.val & rdy_q;
        num_bad  = (i_num_in == 64'd0) || (i_num_in > 64'(MAX_IN));
        start    = (state_q == S_IDLE) && in_hs && !num_bad;
        ram_we   = start || ((state_q == S_LOAD) && in_hs);
        wr_idx   = start ? '0 : wr_addr_q[AW-1:0];
        n_last   = n_q - CW'(1);
        last_wr  = (wr_addr_q == n_last);
        pop      = val_q & o_pnt_scl_if.rdy;
        last_out = pop && (out_addr_q == n_last) && (out_pass_q == PW'(SCL_BITS - 1));
        // Occupancy counts the read in flight and frees the slot popped this cycle,
        // which keeps one beat per cycle flowing with a 2-entry skid.
        occ      = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        issue    = (state_q == S_REPLAY) && !issue_done_q && (occ < 3'd2);
        cnt_d    = cnt_q + 2'(rd_vld_q) - 2'(pop);

        case (state_q)
            S_IDLE:   if (start) state_d = (i_num_in == 64'd1) ? S_REPLAY : S_LOAD;
            S_LOAD:   if (in_hs && last_wr) state_d = S_REPLAY;
            S_REPLAY: if (last_out) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        rdy_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d = (state_d == S_LOAD) || (state_d == S_REPLAY);
    end

    // Pair RAM, 1-cycle read, and skid storage (contents need no reset)
    always_ff @(posedge i_clk) begin
        if (ram_we) ram[wr_idx] <= DAT_W'(i_pnt_scl_if.dat);
        if (issue) rd_dat_q <= ram[rd_addr_q[AW-1:0]];
        if (rd_vld_q) skid_q[wr_ptr_q] <= rd_dat_q;
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            out_addr_q   <= '0;
            rd_pass_q    <= '0;
            out_pass_q   <= '0;
            pass_q       <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            rdy_q        <= 1'b0;
            val_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            val_q    <= (cnt_d != 2'd0);
            cnt_q    <= cnt_d;
            rd_vld_q <= issue;

            if ((state_q == S_IDLE) && in_hs && num_bad) err_q <= 1'b1;

            if (start) begin
                n_q          <= CW'(i_num_in);
                wr_addr_q    <= CW'(1);
                rd_addr_q    <= '0;
                rd_pass_q    <= '0;
                out_addr_q   <= '0;
                out_pass_q   <= '0;
                pass_q       <= '0;
                issue_done_q <= 1'b0;
            end else if (ram_we) begin
                wr_addr_q <= wr_addr_q + CW'(1);
            end

            // Read side walks addr 0..n-1 once per pass
            if (issue) begin
                if (rd_addr_q == n_last) begin
                    rd_addr_q <= '0;
                    if (rd_pass_q == PW'(SCL_BITS - 1)) issue_done_q <= 1'b1;
                    else rd_pass_q <= rd_pass_q + PW'(1);
                end else begin
                    rd_addr_q <= rd_addr_q + CW'(1);
                end
            end

            if (rd_vld_q) wr_ptr_q <= ~wr_ptr_q;

            // Delivery side: o_pass reports the pass of the beat just delivered
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                pass_q   <= out_pass_q;
                if (out_addr_q == n_last) begin
                    out_addr_q <= '0;
                    out_pass_q <= out_pass_q + PW'(1);
                end else begin
                    out_addr_q <= out_addr_q + CW'(1);
                end
            end
        end
    end

    assign i_pnt_scl_if.rdy = rdy_q;
    assign o_pnt_scl_if.val = val_q;
    assign o_pnt_scl_if.sop = val_q;
    assign o_pnt_scl_if.eop = val_q;
    assign o_pnt_scl_if.err = 1'b0;
    assign o_pnt_scl_if.ctl = CTL_BITS'(0);
    assign o_pnt_scl_if.mod = '0;
    assign o_pnt_scl_if.dat = BUS_W'(skid_q[rd_ptr_q]);
    assign o_busy = busy_q;
    assign o_pass = pass_q;
    assign o_err  = err_q;
endmodule

// File: tb/tb_multiexp_pnt_scl_replay.sv
// Directed bench for multiexp_pnt_scl_replay with SCL_BITS=4, MAX_IN=8, 32-bit pairs.
module tb_multiexp_pnt_scl_replay;
    localparam int unsigned DAT_W    = 32;
    localparam int unsigned SCL_BITS = 4;
    localparam int unsigned MAX_IN   = 8;
    localparam int unsigned CTL_BITS = 8;
    localparam int unsigned DAT_BYTS = 4;
    localparam int unsigned PW       = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   num_in = 64'd0;
    logic          busy, err;
    logic [PW-1:0] pass;

    int checks = 0;
    int errors = 0;
    int f_cyc, l_cyc;

    multiexp_pnt_scl_replay_if #(.DAT_BYTS(DAT_BYTS), .CTL_BITS(CTL_BITS)) in_if (), out_if ();

    multiexp_pnt_scl_replay #(
        .DAT_W(DAT_W), .SCL_BITS(SCL_BITS), .MAX_IN(MAX_IN), .CTL_BITS(CTL_BITS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_num_in(num_in),
        .i_pnt_scl_if(in_if), .o_pnt_scl_if(out_if),
        .o_busy(busy), .o_pass(pass), .o_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one host beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [31:0] d, output bit ok);
        int t = 0;
        in_if.val = 1'b1;
        in_if.dat = d;
        while (!in_if.rdy && t < 20) begin
            step();
            t++;
        end
        ok = in_if.rdy;
        step();
        in_if.val = 1'b0;
    endtask

    // Load nb beats with dat = base+i; i_num_in is scrambled after the first beat
    task automatic load_job(input string tag, input logic [63:0] num, input int nb,
                            input logic [31:0] base);
        bit ok;
        num_in = num;
        for (int i = 0; i < nb; i++) begin
            send_beat(base + 32'(i), ok);
            chk({tag, "_load_accept"}, 64'(ok), 64'd1);
            if (i == 0) num_in = 64'hFFFF;
        end
    endtask

    // Collect nexp replay beats; expected beat k is base + (k mod n), pass k/n
    task automatic collect(input string tag, input int nexp, input int n,
                           input logic [31:0] base, input bit rnd,
                           output int first_cyc, output int last_cyc);
        int got = 0;
        bit pv = 1'b0;
        bit phs = 1'b0;
        logic [31:0] pd = '0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 400 && got < nexp; c++) begin
            if (phs) chk({tag, "_pass"}, 64'(pass), 64'((got - 1) / n));
            if (pv && !phs) begin
                chk({tag, "_hold_val"}, 64'(out_if.val), 64'd1);
                chk({tag, "_hold_dat"}, 64'(out_if.dat), 64'(pd));
            end
            chk({tag, "_in_rdy_low"}, 64'(in_if.rdy), 64'd0);
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            out_if.rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_if.val && first_cyc < 0) first_cyc = c;
            if (out_if.val && out_if.rdy) begin
                chk({tag, "_dat"}, 64'(out_if.dat), 64'(base + 32'(got % n)));
                chk({tag, "_sop_eop"}, 64'({out_if.sop, out_if.eop, out_if.err}), 64'(3'b110));
                got++;
                last_cyc = c;
            end
            pv  = out_if.val;
            pd  = out_if.dat;
            phs = out_if.val && out_if.rdy;
            step();
        end
        if (phs) chk({tag, "_pass_last"}, 64'(pass), 64'((got - 1) / n));
        chk({tag, "_count"}, 64'(got), 64'(nexp));
        out_if.rdy = 1'b1;
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_no_out"}, 64'(out_if.val), 64'd0);
            step();
        end
    endtask

    initial begin
        in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.err = 1'b0;
        in_if.ctl = '0;   in_if.mod = '0;   in_if.dat = '0;
        out_if.rdy = 1'b0;

        // Reset state
        step();
        chk("rst_in_rdy", 64'(in_if.rdy), 64'd0);
        chk("rst_out_val", 64'(out_if.val), 64'd0);
        chk("rst_out_side", 64'({out_if.sop, out_if.eop, out_if.err, out_if.ctl, out_if.mod}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_rdy", 64'(in_if.rdy), 64'd1);

        // 1: n=4, sink always ready, back-to-back replay
        load_job("t1", 64'd4, 4, 32'h0);
        collect("t1", 16, 4, 32'h0, 1'b0, f_cyc, l_cyc);
        chk("t1_first_val_latency", 64'(f_cyc), 64'd2);
        chk("t1_back_to_back", 64'(l_cyc - f_cyc), 64'd15);
        chk("t1_busy_done", 64'(busy), 64'd0);
        chk("t1_val_done", 64'(out_if.val), 64'd0);
        step();
        chk("t1_idle_rdy", 64'(in_if.rdy), 64'd1);

        // 2: same job, random sink backpressure
        load_job("t2", 64'd4, 4, 32'h0);
        collect("t2", 16, 4, 32'h0, 1'b1, f_cyc, l_cyc);
        idle_quiet("t2", 4);

        // 3: n=1 with a host beat held pending during replay
        load_job("t3", 64'd1, 1, 32'h55);
        in_if.val = 1'b1;
        in_if.dat = 32'hDEAD;
        chk("t3_pass_start", 64'(pass), 64'd0);
        collect("t3", 4, 1, 32'h55, 1'b0, f_cyc, l_cyc);
        in_if.val = 1'b0;
        chk("t3_pass_end", 64'(pass), 64'd3);
        step();

        // 4: zero count sets err, then a valid n=2 job still replays
        load_job("t4z", 64'd0, 1, 32'h99);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_rdy", 64'(in_if.rdy), 64'd1);
        idle_quiet("t4z", 4);
        load_job("t4", 64'd2, 2, 32'h20);
        collect("t4", 8, 2, 32'h20, 1'b0, f_cyc, l_cyc);
        chk("t4_err_sticky", 64'(err), 64'd1);
        step();

        // 5: count above MAX_IN, then a full-depth job
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t5_err_cleared", 64'(err), 64'd0);
        load_job("t5b", 64'(MAX_IN + 1), 1, 32'h77);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        idle_quiet("t5b", 4);
        load_job("t5", 64'(MAX_IN), MAX_IN, 32'h80);
        collect("t5", 4 * MAX_IN, MAX_IN, 32'h80, 1'b0, f_cyc, l_cyc);
        step();

        // 6: reset mid-replay, then a fresh job
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        load_job("t6", 64'd4, 4, 32'h40);
        collect("t6", 6, 4, 32'h40, 1'b0, f_cyc, l_cyc);
        rst = 1'b1;
        step();
        chk("t6_val_after_rst", 64'(out_if.val), 64'd0);
        chk("t6_busy_after_rst", 64'(busy), 64'd0);
        chk("t6_pass_after_rst", 64'(pass), 64'd0);
        chk("t6_err_after_rst", 64'(err), 64'd0);
        chk("t6_in_rdy_after_rst", 64'(in_if.rdy), 64'd0);
        rst = 1'b0;
        step();
        idle_quiet("t6", 2);
        load_job("t6n", 64'd2, 2, 32'h60);
        collect("t6n", 8, 2, 32'h60, 1'b0, f_cyc, l_cyc);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
